// File: rtl/dnn_fixed_pkg.sv
// Shared fixed-point definitions for the DNN gradient/delta datapath:
// default Q-format, sequencer state encoding, saturation bounds and a
// width-generic clamp helper.
package dnn_fixed_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_FRAC  = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Saturation bounds for the default operand width
    localparam logic [DEF_WIDTH-1:0] SAT_MAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
    localparam logic [DEF_WIDTH-1:0] SAT_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};

    // Clamp a wide signed value into the signed range of a w-bit word (w <= 64).
    // The caller keeps the low w bits of the returned value.
    function automatic logic signed [127:0] fxp_sat(input logic signed [127:0] s,
                                                    input int unsigned       w);
        logic signed [127:0] lim_hi;
        logic signed [127:0] lim_lo;
        lim_hi = (128'sd1 <<< (w - 1)) - 128'sd1;
        lim_lo = -(128'sd1 <<< (w - 1));
        if (s > lim_hi) begin
            return lim_hi;
        end else if (s < lim_lo) begin
            return lim_lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/fxp_mul_step.sv
// One rescaled fixed-point multiply step: full-width signed product,
// arithmetic right shift by FRAC (floor), overflow flag, and reduction back
// to WIDTH bits. Reduction wraps by default; defining MULT_NIN_SATURATE_EN
// clamps an overflowing step to the signed limits instead.
module fxp_mul_step #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24
) (
    input  logic signed [WIDTH-1:0] i_a,
    input  logic signed [WIDTH-1:0] i_b,
    output logic signed [WIDTH-1:0] o_res,
    output logic                    o_ovf
);
`ifdef MULT_NIN_SATURATE_EN
    import dnn_fixed_pkg::*;
`endif

    logic signed [2*WIDTH-1:0] w_p;
    logic signed [2*WIDTH-1:0] w_s;
    logic        [WIDTH:0]     w_hi;

    assign w_p  = (2*WIDTH)'(i_a) * (2*WIDTH)'(i_b);
    assign w_s  = w_p >>> FRAC;
    // In range exactly when the top WIDTH+1 bits are all copies of the sign
    assign w_hi = w_s[2*WIDTH-1:WIDTH-1];
    assign o_ovf = ~((&w_hi) | ~(|w_hi));

`ifdef MULT_NIN_SATURATE_EN
    function automatic logic signed [WIDTH-1:0] sat_reduce(input logic signed [2*WIDTH-1:0] s);
        logic signed [127:0] t;
        t = fxp_sat(128'(s), WIDTH);
        return t[WIDTH-1:0];
    endfunction

    assign o_res = sat_reduce(w_s);
`else
    assign o_res = w_s[WIDTH-1:0];
`endif

endmodule

// File: rtl/mult_nin_seq.sv
// Sequential N-operand signed fixed-point multiplier. A single
// fxp_mul_step is reused once per cycle over the registered operands, with
// valid/ready handshakes on input and output. Optional saturation is
// selected with the MULT_NIN_SATURATE_EN macro (wrap when undefined).
module mult_nin_seq
    import dnn_fixed_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC,
    parameter int N_IN  = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [N_IN*WIDTH-1:0]   i_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic signed [WIDTH-1:0] o,
    output logic                    o_ovf
);
    localparam int               CNT_W = $clog2(N_IN);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_IN - 1);

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [WIDTH-1:0] r_acc;
    logic signed [WIDTH-1:0] r_op [N_IN-1];
    logic                    r_ovf_acc;
    logic signed [WIDTH-1:0] r_o;
    logic                    r_valid;
    logic                    r_ovf;

    logic                    w_accept;
    logic signed [WIDTH-1:0] w_step;
    logic                    w_step_ovf;

    // Operands 1..N_IN-1 shift down one slot per step, so the multiplier
    // always reads slot 0 and no variable index is needed.
    fxp_mul_step #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_step (
        .i_a   (r_acc),
        .i_b   (r_op[0]),
        .o_res (w_step),
        .o_ovf (w_step_ovf)
    );

    // Ready in IDLE, or in DONE when the result is being handed off this cycle
    assign o_ready  = rst_n && ((r_state == IDLE) || ((r_state == DONE) && i_ready));
    assign w_accept = i_valid && o_ready;

    assign o       = r_o;
    assign o_valid = r_valid;
    assign o_ovf   = r_ovf;

    // Sequencer: state, step counter and registered result/flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_o     <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= MULT;
                    end
                end
                MULT: begin
                    if (r_cnt == LAST) begin
                        r_state <= DONE;
                        r_valid <= 1'b1;
                        r_o     <= w_step;
                        r_ovf   <= r_ovf_acc | w_step_ovf;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_state <= w_accept ? MULT : IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_accept) begin
                r_cnt <= CNT_W'(1);
            end else if (r_state == MULT) begin
                r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
            end
        end
    end

    // Operand bank and running accumulator; loaded on accept, advanced per step
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_acc     <= i_data[WIDTH-1:0];
            r_ovf_acc <= 1'b0;
            for (int k = 1; k < N_IN; k++) begin
                r_op[k-1] <= i_data[k*WIDTH +: WIDTH];
            end
        end else if (r_state == MULT) begin
            r_acc     <= w_step;
            r_ovf_acc <= r_ovf_acc | w_step_ovf;
            for (int k = 0; k < N_IN - 2; k++) begin
                r_op[k] <= r_op[k+1];
            end
        end
    end

endmodule
